// File: rtl/mux_chan_scanner.sv
// Registered N:1 channel selector with manual select and idle-skipping scan sweep.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; out-of-range manual select pulses err
// SCAN  | visiting channel idx; loads it if manual or in_valid[idx]
// WAIT  | word presented on out_*, held until out_ready handshake
// DONE  | one-cycle done pulse, then back to IDLE
module mux_chan_scanner #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      start,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    // One extra bit so sel >= CHANNELS is detectable when CHANNELS is a power of two.
    localparam logic [SEL_W:0]   CHAN_CNT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    state_t           state;
    logic [SEL_W-1:0] idx;
    logic             mode_q;
    logic             sel_bad;
    logic [WIDTH-1:0] chan_word [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign chan_word[k] = in_data[k*WIDTH +: WIDTH];
    end

    // Manual request pointing past the last channel.
    always_comb begin
        sel_bad = ({1'b0, sel} >= CHAN_CNT);
    end

    // Sequencer: all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            mode_q    <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        if (!mode && sel_bad) begin
                            err <= 1'b1;
                        end else begin
                            idx   <= mode ? '0 : sel;
                            state <= SCAN;
                            busy  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (!mode_q || in_valid[idx]) begin
                        out_data  <= chan_word[idx];
                        out_chan  <= idx;
                        out_valid <= 1'b1;
                        state     <= WAIT;
                    end else if (idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!mode_q || idx == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
